dmem_responder: RTL and testbench

- Multi-cycle data-memory responder: the memory-side end of the processor's data interface (address, write data, write strobe in; read data out).
- Adds a request/ready handshake with a programmable wait-state count, so the core and its tests can run against slow memory instead of the zero-latency single-cycle dmem.
- Sits between the core's load/store port and a word-addressed storage array, at top level in place of dmem.

---
 rtl/arm_mem_pkg.sv | 27 ++
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_responder.sv | 126 ++++++++++++
 tb/tb_dmem_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// +----------------------------------------------------------------------------+
// | arm_mem_pkg : shared types for the multi-cycle data-memory responder.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package arm_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic              we;
    logic [31:0]       addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dmem_req_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// +----------------------------------------------------------------------------+
// | dmem_array : word array, synchronous byte-masked write, asynchronous read. |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_array
  import arm_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     index,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem_q[index][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[index];

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// +----------------------------------------------------------------------------+
// | dmem_responder : req/ready data-memory responder with LATENCY wait states. |
// | Option macro DMEM_BYTEEN_EN adds the be port for byte-masked stores.       |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_responder
  import arm_mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [WORD_W-1:0] wdata,
`ifdef DMEM_BYTEEN_EN
  input  logic [BE_W-1:0]   be,
`endif
  output logic              ready,
  output logic [WORD_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam int CW = 4;

  dmem_state_t       state_q;
  logic [CW-1:0]     cnt_q;
  dmem_req_t         req_q;
  dmem_req_t         req_d;
  logic              ready_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;
  logic              busy_q;

  logic              in_range;
  logic              commit;
  logic              arr_we;
  logic [AW-1:0]     index;
  logic [WORD_W-1:0] arr_rdata;
  logic              unused_addr_bits;

  always_comb begin
    req_d.we    = we;
    req_d.addr  = addr;
    req_d.wdata = wdata;
`ifdef DMEM_BYTEEN_EN
    req_d.be    = be;
`else
    req_d.be    = '1;
`endif
  end

  // Everything downstream of acceptance works from the captured copy only.
  assign index            = req_q.addr[AW+1:2];
  assign in_range         = ~|req_q.addr[31:AW+2];
  assign commit           = (state_q == WAIT) && (cnt_q == '0);
  assign arr_we           = commit && req_q.we && in_range;
  assign unused_addr_bits = ^req_q.addr[1:0];

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .index (index),
    .wdata (req_q.wdata),
    .be    (req_q.be),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (req) begin
            req_q   <= req_d;
            cnt_q   <= CW'(LATENCY - 1);
            busy_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= ~in_range;
            rdata_q <= (!req_q.we && in_range) ? arr_rdata : '0;
            state_q <= RESP;
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// +----------------------------------------------------------------------------+
// | tb_dmem_responder : directed table, corner sequences and random traffic.   |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata;
`ifdef DMEM_BYTEEN_EN
  logic [3:0]  be;
`endif
  logic        ready, err, busy;
  logic [31:0] rdata;

  logic [1:0]  s_req;
  logic [1:0]  s_ready, s_err, s_busy;
  logic [31:0] s_rdata [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] mdl [DEPTH];
  logic [3:0]  mv  [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTEEN_EN
    .be(be),
`endif
    .ready(ready), .rdata(rdata), .err(err), .busy(busy));

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req(s_req[0]), .we(we), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTEEN_EN
    .be(be),
`endif
    .ready(s_ready[0]), .rdata(s_rdata[0]), .err(s_err[0]), .busy(s_busy[0]));

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(5)) u_l5 (
    .clk(clk), .reset(reset), .req(s_req[1]), .we(we), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTEEN_EN
    .be(be),
`endif
    .ready(s_ready[1]), .rdata(s_rdata[1]), .err(s_err[1]), .busy(s_busy[1]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One complete transaction on the main DUT; inputs are scrambled after
  // acceptance so only the captured request can produce the right answer.
  task automatic access(input string nm, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output logic e);
    int lat, bc, idx;
    logic [3:0] eb;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
`ifdef DMEM_BYTEEN_EN
    be = b;
    eb = b;
`else
    eb = 4'hF;
`endif
    lat = 0; bc = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        we = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
`ifdef DMEM_BYTEEN_EN
        be = 4'($urandom);
`endif
      end
      if (busy) bc++;
    end while (!ready && lat < 40);
    check({nm, "_timeout"}, {31'd0, ready}, 32'd1);
    check({nm, "_latency"}, lat, LAT + 1);
    check({nm, "_busy_cycles"}, bc, LAT);
    rd = rdata; e = err;
    req = 1'b0;
    @(posedge clk); #1;
    check({nm, "_pulse_width"}, {31'd0, ready}, 32'd0);
    if (w && a < DEPTH * 4) begin
      idx = int'(a) / 4;
      for (int k = 0; k < 4; k++)
        if (eb[k]) begin mdl[idx][8*k +: 8] = d[8*k +: 8]; mv[idx][k] = 1'b1; end
    end
  endtask

  task automatic sweep(input int i, input int L);
    int n, bc;
    @(negedge clk);
    s_req[i] = 1'b1; we = 1'b0; addr = 32'h10;
    n = 0; bc = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (s_busy[i]) bc++;
    end while (!s_ready[i] && n < 40);
    check($sformatf("sweep%0d_latency", L), n, L + 1);
    check($sformatf("sweep%0d_busy", L), bc, L);
    check($sformatf("sweep%0d_err", L), {31'd0, s_err[i]}, 32'd0);
    @(negedge clk);
    s_req[i] = 1'b0;
    @(posedge clk); #1;
    check($sformatf("sweep%0d_pulse", L), {31'd0, s_ready[i]}, 32'd0);
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [31:0] rd;
    logic        e;
    logic [31:0] bb_addr [4];
    logic [31:0] bb_data [4];
    int          t_rdy [4];
    int          n;

    tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};
    tbl[2] = '{1'b1, 32'h0000_0000, 32'h1111_1111, 4'hF, 32'h0000_0000, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
    tbl[4] = '{1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b1};
    tbl[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'h1111_1111, 1'b0};
    tbl[6] = '{1'b1, 32'h0000_00FC, 32'h0000_CAFE, 4'hF, 32'h0000_0000, 1'b0};
    tbl[7] = '{1'b0, 32'h0000_00FF, 32'h0000_0000, 4'hF, 32'h0000_CAFE, 1'b0};
    tbl[8] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};

    for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; mv[i] = '0; end
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; s_req = '0;
`ifdef DMEM_BYTEEN_EN
    be = 4'hF;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      access($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b, rd, e);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
    end

    sweep(0, 1);
    sweep(1, 5);

    // Reset lands in WAIT of a store: the write and the pulse must vanish.
    access("pre20", 1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, rd, e);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
`ifdef DMEM_BYTEEN_EN
    be = 4'hF;
`endif
    @(posedge clk); #1;
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready) n++;
    end
    check("midrst_no_ready", n, 0);
    @(negedge clk);
    req = 1'b0; reset = 1'b0;
    access("post20", 1'b0, 32'h20, 32'h0, 4'hF, rd, e);
    check("midrst_data_kept", rd, 32'h0BAD_F00D);

`ifdef DMEM_BYTEEN_EN
    access("be_full", 1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF, rd, e);
    access("be_low",  1'b1, 32'h8, 32'h0000_00AA, 4'h1, rd, e);
    access("be_ld1",  1'b0, 32'h8, 32'h0, 4'h0, rd, e);
    check("be_merge", rd, 32'hFFFF_FFAA);
    access("be_none", 1'b1, 32'h8, 32'h1234_5678, 4'h0, rd, e);
    check("be_none_err", {31'd0, e}, 32'd0);
    access("be_ld2",  1'b0, 32'h8, 32'h0, 4'hF, rd, e);
    check("be_none_kept", rd, 32'hFFFF_FFAA);
`endif

    // Back-to-back loads with req held high across all four.
    bb_addr = '{32'h10, 32'h0, 32'hFC, 32'h20};
    bb_data = '{32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_CAFE, 32'h0BAD_F00D};
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = bb_addr[0];
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!ready && n < 40);
      check($sformatf("b2b%0d_timeout", i), {31'd0, ready}, 32'd1);
      check($sformatf("b2b%0d_rdata", i), rdata, bb_data[i]);
      t_rdy[i] = cyc;
      if (i < 3) addr = bb_addr[i+1];
    end
    req = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b%0d_spacing", i), t_rdy[i+1] - t_rdy[i], LAT + 2);

    // Random traffic against the word-array model.
    for (int it = 0; it < 150; it++) begin
      bit          w, inr;
      logic [31:0] a, d;
      logic [3:0]  b;
      int          idx;
      logic [31:0] exp_word;
      bit          known;
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h100;
      else a = 32'($urandom_range(0, DEPTH * 4 - 1));
      d = $urandom;
      b = 4'($urandom_range(0, 15));
      inr = (a < DEPTH * 4);
      idx = inr ? int'(a) / 4 : 0;
      known = inr && (mv[idx] == 4'hF);
      exp_word = mdl[idx];
      access($sformatf("rnd%0d", it), w, a, d, b, rd, e);
      check($sformatf("rnd%0d_err", it), {31'd0, e}, {31'd0, !inr});
      if (!inr || w) check($sformatf("rnd%0d_rdata0", it), rd, 32'd0);
      else if (known) check($sformatf("rnd%0d_rdata", it), rd, exp_word);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
